// File: rtl/mhp_echo_node_pkg.sv
// Shared MHP definitions: header layout, dtype fields,
// node FSM states and the frame length helper.
package mhp_pkg;

  localparam int HDR_LEN = 7;
  localparam int OFF_DST = 0;
  localparam int OFF_SRC = 2;
  localparam int OFF_LEN = 4;
  localparam int OFF_DTYPE = 6;
  localparam int DTYPE_REPLY_BIT = 7;
  localparam logic [6:0] PING_TYPE_DEF = 7'h01;

  typedef enum logic [2:0] {
    IDLE,
    RX_POP,
    RX_CAP,
    RX_DRAIN,
    DECIDE,
    TX,
    TX_DONE
  } state_t;

  // On-wire length: header plus data, padded to the minimum.
  function automatic logic [15:0] frame_len(
    input logic [15:0] len,
    input logic [15:0] min_n
  );
    logic [15:0] n;
    n = len + 16'(HDR_LEN);
    return (n < min_n) ? min_n : n;
  endfunction

endpackage

// File: rtl/mhp_echo_node_if.sv
// Byte FIFO and UART tap signals of the MHP node.
// master is the node side, slave the environment.
interface mhp_echo_node_if;
  logic        i_send;
  logic        o_done;
  logic [7:0]  i_rdata;
  logic        i_rready;
  logic        o_rreq;
  logic [7:0]  o_wdata;
  logic        i_wready;
  logic        o_wvalid;
  logic        o_wvalid_u;
  logic [7:0]  o_wdata_u;
  logic [15:0] o_drop_cnt;

  modport master (
    input  i_send, i_rdata, i_rready, i_wready,
    output o_done, o_rreq, o_wdata, o_wvalid,
    output o_wvalid_u, o_wdata_u, o_drop_cnt
  );

  modport slave (
    output i_send, i_rdata, i_rready, i_wready,
    input  o_done, o_rreq, o_wdata, o_wvalid,
    input  o_wvalid_u, o_wdata_u, o_drop_cnt
  );
endinterface

// File: rtl/mhp_echo_node_buf.sv
// Frame buffer: single-port RAM, synchronous read,
// one cycle of read latency.
module mhp_frame_buf #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  // Write when enabled, always read the addressed byte.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mhp_echo_node.sv
// MHP echo endpoint: buffers an RX frame, answers pings,
// mirrors RX bytes to UART, sends broadcast pings.
import mhp_pkg::*;

module mhp_echo_node #(
  parameter int          BUF_DEPTH   = 1024,
  parameter int          MIN_PAYLOAD = 46,
  parameter logic [15:0] MY_ADDR     = 16'h0001,
  parameter logic [6:0]  PING_TYPE   = PING_TYPE_DEF
) (
  input logic             i_clk,
  input logic             i_rst,
  mhp_echo_node_if.master bus
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [15:0] MIN_N = 16'(MIN_PAYLOAD);
  localparam logic [15:0] MAX_LEN = 16'(BUF_DEPTH - HDR_LEN);
  localparam logic [15:0] LEN_LO = 16'(OFF_LEN + 1);

  state_t        state;
  logic [15:0]   cnt, frame_n, dst, src, len;
  logic [15:0]   nxt, len_n, fn_eff;
  logic [7:0]    dtype, ram_q, tx_byte;
  logic          drop, cap, send_pend;
  logic          fire, big, ours, ram_we;
  logic [AW-1:0] ram_addr;

  mhp_frame_buf #(.DEPTH(BUF_DEPTH), .AW(AW)) u_buf (
    .clk   (i_clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (bus.i_rdata),
    .rdata (ram_q)
  );

  // TX reads run one byte ahead so ram_q holds byte cnt+1.
  always_comb begin
    fire   = bus.o_wvalid & bus.i_wready;
    nxt    = cnt + 16'd1;
    len_n  = {len[15:8], bus.i_rdata};
    big    = (cnt == LEN_LO) && (len_n > MAX_LEN);
    fn_eff = (cnt == LEN_LO) ? frame_len(len_n, MIN_N)
                             : frame_n;
    ours   = !drop
           && (dst == MY_ADDR || dst == 16'hFFFF)
           && !dtype[DTYPE_REPLY_BIT]
           && dtype[6:0] == PING_TYPE
           && src != MY_ADDR;
    ram_we = (state == RX_CAP) && cap;
    if (state == TX)
      ram_addr = fire ? AW'(cnt + 16'd2) : AW'(nxt);
    else if (state == RX_CAP)
      ram_addr = AW'(cnt);
    else
      ram_addr = AW'(1);
    case (nxt)
      16'(OFF_DST + 1):   tx_byte = src[7:0];
      16'(OFF_SRC):       tx_byte = MY_ADDR[15:8];
      16'(OFF_SRC + 1):   tx_byte = MY_ADDR[7:0];
      16'(OFF_LEN):       tx_byte = len[15:8];
      16'(OFF_LEN + 1):   tx_byte = len[7:0];
      16'(OFF_DTYPE):     tx_byte = dtype;
      default:
        tx_byte = (nxt < len + 16'(HDR_LEN)) ? ram_q
                                             : 8'h00;
    endcase
  end

  // Node FSM with registered FIFO, UART and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      cnt            <= '0;
      frame_n        <= '0;
      dst            <= '0;
      src            <= '0;
      len            <= '0;
      dtype          <= '0;
      drop           <= 1'b0;
      cap            <= 1'b0;
      send_pend      <= 1'b0;
      bus.o_done     <= 1'b0;
      bus.o_rreq     <= 1'b0;
      bus.o_wdata    <= '0;
      bus.o_wvalid   <= 1'b0;
      bus.o_wvalid_u <= 1'b0;
      bus.o_wdata_u  <= '0;
      bus.o_drop_cnt <= '0;
    end else begin
      bus.o_rreq     <= 1'b0;
      bus.o_wvalid_u <= 1'b0;
      bus.o_done     <= 1'b0;
      cap            <= bus.o_rreq;
      if (bus.i_send) send_pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (bus.i_rready) begin
            state      <= RX_POP;
            bus.o_rreq <= 1'b1;
            cnt        <= '0;
            drop       <= 1'b0;
            frame_n    <= 16'hFFFF;
          end else if (send_pend) begin
            state        <= TX;
            send_pend    <= 1'b0;
            cnt          <= '0;
            frame_n      <= MIN_N;
            src          <= 16'hFFFF;
            len          <= '0;
            dtype        <= {1'b0, PING_TYPE};
            bus.o_wdata  <= 8'hFF;
            bus.o_wvalid <= 1'b1;
          end
        end
        RX_POP: state <= RX_CAP;
        RX_CAP: begin
          if (cap) begin
            bus.o_wvalid_u <= 1'b1;
            bus.o_wdata_u  <= bus.i_rdata;
            cnt            <= nxt;
            case (cnt)
              16'(OFF_DST):     dst[15:8] <= bus.i_rdata;
              16'(OFF_DST + 1): dst[7:0] <= bus.i_rdata;
              16'(OFF_SRC):     src[15:8] <= bus.i_rdata;
              16'(OFF_SRC + 1): src[7:0] <= bus.i_rdata;
              16'(OFF_LEN):     len[15:8] <= bus.i_rdata;
              16'(OFF_LEN + 1): len[7:0] <= bus.i_rdata;
              16'(OFF_DTYPE):   dtype <= bus.i_rdata;
              default: ;
            endcase
            if (cnt == LEN_LO) frame_n <= fn_eff;
            if (big) begin
              drop  <= 1'b1;
              state <= RX_DRAIN;
            end else if (nxt == fn_eff) begin
              state <= DECIDE;
            end else if (bus.i_rready) begin
              state      <= RX_POP;
              bus.o_rreq <= 1'b1;
            end
          end else if (bus.i_rready) begin
            state      <= RX_POP;
            bus.o_rreq <= 1'b1;
          end
        end
        RX_DRAIN: begin
          if (cap) begin
            bus.o_wvalid_u <= 1'b1;
            bus.o_wdata_u  <= bus.i_rdata;
          end
          if (!bus.o_rreq) begin
            if (bus.i_rready) bus.o_rreq <= 1'b1;
            else state <= DECIDE;
          end
        end
        DECIDE: begin
          if (ours) begin
            state        <= TX;
            cnt          <= '0;
            dtype        <= {1'b1, PING_TYPE};
            bus.o_wdata  <= src[15:8];
            bus.o_wvalid <= 1'b1;
          end else begin
            state <= IDLE;
            if (bus.o_drop_cnt != 16'hFFFF)
              bus.o_drop_cnt <= bus.o_drop_cnt + 16'd1;
          end
        end
        TX: begin
          if (fire) begin
            if (nxt == frame_n) begin
              bus.o_wvalid <= 1'b0;
              bus.o_done   <= 1'b1;
              state        <= TX_DONE;
            end else begin
              bus.o_wdata <= tx_byte;
              cnt         <= nxt;
            end
          end
        end
        TX_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mhp_echo_node.sv
// Directed bench for mhp_echo_node: FIFO models plus
// scoreboards for TX frames and UART mirror bytes.
module tb_mhp_echo_node;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mhp_echo_node_if bus();

  mhp_echo_node #(
    .BUF_DEPTH   (1024),
    .MIN_PAYLOAD (46),
    .MY_ADDR     (16'h0001),
    .PING_TYPE   (7'h01)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int tx_cnt = 0;
  int u_cnt = 0;
  int pop_cnt = 0;
  logic [7:0] rxq[$];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_u[$];
  bit toggle = 1'b0;
  bit stalled = 1'b0;
  logic [7:0] held;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push_rx(input logic [15:0] dst,
                         input logic [15:0] src,
                         input logic [15:0] len,
                         input logic [7:0] dt,
                         input logic [7:0] data[$],
                         input int total);
    logic [7:0] f[$];
    f = {dst[15:8], dst[7:0], src[15:8], src[7:0],
         len[15:8], len[7:0], dt};
    foreach (data[i]) f.push_back(data[i]);
    while (f.size() < total) f.push_back(8'h00);
    foreach (f[i]) begin
      rxq.push_back(f[i]);
      exp_u.push_back(f[i]);
    end
  endtask

  task automatic push_reply(input logic [15:0] to,
                            input logic [7:0] data[$]);
    logic [15:0] l;
    int n;
    l = 16'(data.size());
    n = 7 + data.size();
    if (n < 46) n = 46;
    exp_tx.push_back(to[15:8]);
    exp_tx.push_back(to[7:0]);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h01);
    exp_tx.push_back(l[15:8]);
    exp_tx.push_back(l[7:0]);
    exp_tx.push_back(8'h81);
    foreach (data[i]) exp_tx.push_back(data[i]);
    for (int i = 7 + data.size(); i < n; i++)
      exp_tx.push_back(8'h00);
  endtask

  task automatic push_bcast();
    exp_tx.push_back(8'hFF);
    exp_tx.push_back(8'hFF);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h01);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h01);
    for (int i = 7; i < 46; i++) exp_tx.push_back(8'h00);
  endtask

  task automatic wait_done(input int target,
                           input string tag);
    int n;
    n = 0;
    while (done_cnt < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk(tag, done_cnt, target);
  endtask

  task automatic wait_rx();
    int n;
    n = 0;
    while (rxq.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("rx_consumed", rxq.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"}, bus.o_done, 0);
    chk({tag, "_rreq"}, bus.o_rreq, 0);
    chk({tag, "_wvalid"}, bus.o_wvalid, 0);
    chk({tag, "_wdata"}, bus.o_wdata, 0);
    chk({tag, "_wvalid_u"}, bus.o_wvalid_u, 0);
    chk({tag, "_wdata_u"}, bus.o_wdata_u, 0);
    chk({tag, "_drop"}, bus.o_drop_cnt, 0);
  endtask

  // RX FIFO model: pop on o_rreq, data valid next cycle.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.o_rreq === 1'b1) begin
      pop_cnt++;
      if (rxq.size() != 0) bus.i_rdata = rxq.pop_front();
    end
    bus.i_rready = (rxq.size() != 0);
  end

  // TX sink ready: steady or alternating each cycle.
  always @(posedge clk) begin
    #1;
    bus.i_wready = toggle ? ~bus.i_wready : 1'b1;
  end

  // Output monitor: TX and UART scoreboards, done pulses.
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      stalled = 1'b0;
    end else begin
      if (stalled && bus.o_wvalid)
        chk("tx_stable", bus.o_wdata, held);
      if (bus.o_wvalid && bus.i_wready) begin
        tx_cnt++;
        chk("tx_expected", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0)
          chk("tx_byte", bus.o_wdata, exp_tx.pop_front());
      end
      stalled = bus.o_wvalid && !bus.i_wready;
      held = bus.o_wdata;
      if (bus.o_wvalid_u) begin
        u_cnt++;
        chk("uart_expected", exp_u.size() != 0, 1);
        if (exp_u.size() != 0)
          chk("uart_byte", bus.o_wdata_u, exp_u.pop_front());
      end
      if (bus.o_done) done_cnt++;
    end
  end

  initial begin
    logic [7:0] d[$];
    logic [7:0] e[$];
    int base;
    int n;
    rst = 1'b1;
    bus.i_send = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    d = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    push_reply(16'h0055, d);
    push_rx(16'h0001, 16'h0055, 16'd4, 8'h01, d, 46);
    wait_done(1, "t1_done");
    chk("t1_tx", tx_cnt, 46);
    chk("t1_uart", u_cnt, 46);
    chk("t1_pops", pop_cnt, 46);
    chk("t1_drop", bus.o_drop_cnt, 0);
    chk("t1_left", exp_tx.size(), 0);

    push_rx(16'h0002, 16'h0055, 16'd4, 8'h01, d, 46);
    wait_rx();
    chk("t2_drop", bus.o_drop_cnt, 1);
    chk("t2_uart", u_cnt, 92);
    chk("t2_pops", pop_cnt, 92);
    chk("t2_tx", tx_cnt, 46);

    e = {};
    for (int i = 0; i < 53; i++) e.push_back(8'(i + 3));
    push_rx(16'h0001, 16'h0055, 16'd1100, 8'h01, e, 60);
    wait_rx();
    chk("t3_drop", bus.o_drop_cnt, 2);
    chk("t3_uart", u_cnt, 152);
    chk("t3_pops", pop_cnt, 152);
    chk("t3_tx", tx_cnt, 46);

    e = {};
    push_rx(16'hFFFF, 16'h0001, 16'd0, 8'h01, e, 46);
    wait_rx();
    chk("self_drop", bus.o_drop_cnt, 3);
    chk("self_tx", tx_cnt, 46);

    d = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    push_reply(16'h0033, d);
    push_bcast();
    push_rx(16'h0001, 16'h0033, 16'd5, 8'h01, d, 46);
    repeat (10) @(posedge clk);
    #1 bus.i_send = 1'b1;
    @(posedge clk);
    #1 bus.i_send = 1'b0;
    wait_done(3, "t4_done");
    chk("t4_tx", tx_cnt, 138);
    chk("t4_drop", bus.o_drop_cnt, 3);
    chk("t4_left", exp_tx.size(), 0);

    toggle = 1'b1;
    d = {8'h11, 8'h22, 8'h33};
    push_reply(16'h0077, d);
    push_rx(16'hFFFF, 16'h0077, 16'd3, 8'h01, d, 46);
    wait_done(4, "t5_done");
    toggle = 1'b0;
    chk("t5_tx", tx_cnt, 184);
    chk("t5_left", exp_tx.size(), 0);

    d = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    push_reply(16'h0055, d);
    push_rx(16'h0001, 16'h0055, 16'd4, 8'h01, d, 46);
    base = tx_cnt;
    n = 0;
    while (tx_cnt < base + 10 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach", tx_cnt >= base + 10, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_tx.delete();
    @(posedge clk);
    @(negedge clk);
    chk_zero("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    base = tx_cnt;
    push_reply(16'h0055, d);
    push_rx(16'h0001, 16'h0055, 16'd4, 8'h01, d, 46);
    wait_done(5, "t6_done");
    chk("t6_tx", tx_cnt, base + 46);
    chk("t6_left", exp_tx.size(), 0);
    chk("t6_drop", bus.o_drop_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
